// File: rtl/pmu_cfg_pkg.sv
// Shared definitions for the PMU configuration arbiter: FSM states and the
// PMU_raw register map of the 24-counter / 6-core configuration.
package pmu_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LATCH  = 2'd1,
    COMMIT = 2'd2,
    HOLD   = 2'd3
  } cfg_state_e;

  localparam int REG_BITS      = 32;
  localparam int TB_N_COUNTERS = 24;
  localparam int TB_N_CORES    = 6;
  localparam int MCCU_EVENTS   = 6;  // event lines per core feeding the RDC
  localparam int XBAR_SEL_BITS = 8;  // crossbar select field per counter

  function automatic int mccu_regs(input int n_cores);
    return 1 + 2 * n_cores;
  endfunction

  function automatic int rdc_watermark_regs(input int n_cores);
    return (n_cores * MCCU_EVENTS + 3) / 4;
  endfunction

  function automatic int crossbar_regs(input int n_counters);
    return (n_counters * XBAR_SEL_BITS + REG_BITS - 1) / REG_BITS;
  endfunction

  function automatic int pmu_total_regs(input int n_counters, input int n_cores);
    return 1 + n_counters + 1 + mccu_regs(n_cores) + 1
           + rdc_watermark_regs(n_cores) + crossbar_regs(n_counters);
  endfunction

  localparam int BASE_CFG           = 0;
  localparam int BASE_COUNTERS      = BASE_CFG + 1;
  localparam int BASE_OVERFLOW      = BASE_COUNTERS + TB_N_COUNTERS;
  localparam int BASE_MCCU          = BASE_OVERFLOW + 1;
  localparam int BASE_RDC_VECT      = BASE_MCCU + mccu_regs(TB_N_CORES);
  localparam int BASE_RDC_WATERMARK = BASE_RDC_VECT + 1;
  localparam int BASE_CROSSBAR      = BASE_RDC_WATERMARK + rdc_watermark_regs(TB_N_CORES);
  localparam int TB_TOTAL_NREGS     = pmu_total_regs(TB_N_COUNTERS, TB_N_CORES);

endpackage

// File: rtl/pmu_cfg_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at the index after the
// last grant and returns a one-hot grant (all zero when nothing requests).
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] && (j == (int'(last) + i) % N)) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pmu_cfg_arbiter.sv
// Multi-requester register port for PMU_raw: round-robin arbitration,
// read-modify-write merge against live feedback, and a lock with idle timeout.
module pmu_cfg_arbiter
  import pmu_cfg_pkg::*;
#(
  parameter int REG_WIDTH    = 32,
  parameter int N_REGS       = 55,
  parameter int N_REQ        = 2,
  parameter int LOCK_TIMEOUT = 64,
  localparam int AW = $clog2(N_REGS)
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ-1:0]            we_i,
  input  logic [N_REQ*AW-1:0]         addr_i,
  input  logic [N_REQ*REG_WIDTH-1:0]  wdata_i,
  input  logic [N_REQ-1:0]            lock_i,
  output logic [N_REQ-1:0]            ack_o,
  output logic                        err_o,
  output logic [REG_WIDTH-1:0]        rdata_o,
  output logic [N_REQ-1:0]            lock_lost_o,
  input  logic [N_REGS*REG_WIDTH-1:0] pmu_regs_fb_i,
  output logic [N_REGS*REG_WIDTH-1:0] pmu_regs_o,
  output logic                        pmu_we_o,
  output logic [1:0]                  state_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  // Handshake: req_i is a level request whose we/addr/wdata stay stable until
  // the single-cycle ack_o pulse; ack_o is the only completion indication.

  cfg_state_e           state_q, state_d;
  logic [IW-1:0]        owner_q, rr_ptr_q, win_idx, sel_idx;
  logic                 lat_we_q, err_q;
  logic [AW-1:0]        lat_addr_q, sel_addr;
  logic [REG_WIDTH-1:0] lat_wdata_q, rdata_q, sel_wdata, fb_word;
  logic [TW-1:0]        tmo_q;
  logic [N_REQ-1:0]     grant;
  logic                 sel_we, owner_req, owner_lock, in_range;
  logic                 load, commit, lost, tmo_clr, tmo_inc;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (req_i),
    .last  (rr_ptr_q),
    .grant (grant)
  );

  // Request selection: the arbitration winner in IDLE, the lock owner in HOLD.
  always_comb begin
    win_idx = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (grant[j]) win_idx = IW'(j);
    end
    sel_idx    = (state_q == IDLE) ? win_idx : owner_q;
    sel_we     = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (sel_idx == IW'(j)) begin
        sel_we    = we_i[j];
        sel_addr  = addr_i[j*AW +: AW];
        sel_wdata = wdata_i[j*REG_WIDTH +: REG_WIDTH];
      end
      if (owner_q == IW'(j)) begin
        owner_req  = req_i[j];
        owner_lock = lock_i[j];
      end
    end
  end

  always_comb begin
    in_range = int'(lat_addr_q) < N_REGS;
    fb_word  = '0;
    for (int r = 0; r < N_REGS; r++) begin
      if (lat_addr_q == AW'(r)) fb_word = pmu_regs_fb_i[r*REG_WIDTH +: REG_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    commit  = 1'b0;
    lost    = 1'b0;
    tmo_clr = 1'b0;
    tmo_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          load    = 1'b1;
          state_d = LATCH;
        end
      end
      LATCH: state_d = COMMIT;
      COMMIT: begin
        commit  = 1'b1;
        tmo_clr = 1'b1;
        state_d = owner_lock ? HOLD : IDLE;
      end
      HOLD: begin
        if (owner_req) begin
          load    = 1'b1;
          tmo_clr = 1'b1;
          state_d = LATCH;
        end else if (!owner_lock) begin
          state_d = IDLE;
        end else begin
          tmo_inc = 1'b1;
          // The increment in this cycle is the one that reaches LOCK_TIMEOUT.
          if (tmo_q == TW'(LOCK_TIMEOUT - 1)) begin
            lost    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      owner_q     <= '0;
      rr_ptr_q    <= IW'(N_REQ - 1);
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
    end else begin
      if (load) begin
        owner_q     <= sel_idx;
        lat_we_q    <= sel_we;
        lat_addr_q  <= sel_addr;
        lat_wdata_q <= sel_wdata;
      end
      if (state_q == LATCH) begin
        err_q   <= !in_range;
        rdata_q <= in_range ? fb_word : '0;
      end
      if (commit) rr_ptr_q <= owner_q;
      if (tmo_clr) tmo_q <= '0;
      else if (tmo_inc && tmo_q != TW'(LOCK_TIMEOUT)) tmo_q <= tmo_q + 1'b1;
    end
  end

  always_comb begin
    for (int j = 0; j < N_REQ; j++) begin
      ack_o[j]       = commit && (owner_q == IW'(j));
      lock_lost_o[j] = lost && (owner_q == IW'(j));
    end
    err_o    = commit && err_q;
    rdata_o  = commit ? rdata_q : '0;
    pmu_we_o = commit && lat_we_q && !err_q;
    // Everything but the target entry is echoed back from live feedback.
    pmu_regs_o = pmu_regs_fb_i;
    for (int r = 0; r < N_REGS; r++) begin
      if (pmu_we_o && lat_addr_q == AW'(r)) pmu_regs_o[r*REG_WIDTH +: REG_WIDTH] = lat_wdata_q;
    end
    state_o = state_q;
  end

endmodule
